// File: rtl/trivium_pkg.sv
// Shared Trivium constants: state geometry, tap positions and the decryptor FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package trivium_pkg;

  localparam int STATE_W       = 288;
  localparam int KEY_W         = 80;
  localparam int IV_W          = 80;
  localparam int WARMUP_ROUNDS = 1152;

  // Register boundaries, 1-based positions of the last bit of each shift register
  localparam int REG_A_END = 93;
  localparam int REG_B_END = 177;

  // IV lands starting at s94
  localparam int IV_POS = 94;

  // Tap positions, 1-based as in s1..s288
  localparam int T1_A    = 66;
  localparam int T1_B    = 93;
  localparam int T1_AND0 = 91;
  localparam int T1_AND1 = 92;
  localparam int T1_FB   = 171;

  localparam int T2_A    = 162;
  localparam int T2_B    = 177;
  localparam int T2_AND0 = 175;
  localparam int T2_AND1 = 176;
  localparam int T2_FB   = 264;

  localparam int T3_A    = 243;
  localparam int T3_B    = 288;
  localparam int T3_AND0 = 286;
  localparam int T3_AND1 = 287;
  localparam int T3_FB   = 69;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    FILL = 2'd2,
    FULL = 2'd3
  } dec_state_e;

endpackage

// File: rtl/trivium_core.sv
// Trivium state register with key/IV load mux and a single-step update; z is taken from the current state.
// Latency: load or step takes effect on the next rising edge; z is combinational from the state.
// Backpressure: none; the state holds whenever neither load nor step is asserted.
import trivium_pkg::*;

module trivium_core (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [KEY_W-1:0]   key,
  input  logic [IV_W-1:0]    iv,
  input  logic               step,
  output logic               z,
  output logic [STATE_W-1:0] state
);

  // Bit s(i) of the cipher lives at state_q[i-1]
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] load_val;
  logic [STATE_W-1:0] step_val;
  logic               t1, t2, t3;
  logic               t1_fb, t2_fb, t3_fb;

  // Tap XORs, keystream bit and nonlinear feedback terms
  always_comb begin
    t1    = state_q[T1_A-1] ^ state_q[T1_B-1];
    t2    = state_q[T2_A-1] ^ state_q[T2_B-1];
    t3    = state_q[T3_A-1] ^ state_q[T3_B-1];
    z     = t1 ^ t2 ^ t3;
    t1_fb = t1 ^ (state_q[T1_AND0-1] & state_q[T1_AND1-1]) ^ state_q[T1_FB-1];
    t2_fb = t2 ^ (state_q[T2_AND0-1] & state_q[T2_AND1-1]) ^ state_q[T2_FB-1];
    t3_fb = t3 ^ (state_q[T3_AND0-1] & state_q[T3_AND1-1]) ^ state_q[T3_FB-1];
  end

  // Session load image and shifted state; load wins over step
  always_comb begin
    load_val                     = '0;
    load_val[KEY_W-1:0]          = key;
    load_val[IV_POS-1 +: IV_W]   = iv;
    load_val[STATE_W-1 -: 3]     = 3'b111;
    // Each register shifts toward higher positions and takes feedback from the previous one
    step_val = {state_q[STATE_W-2:REG_B_END], t2_fb,
                state_q[REG_B_END-2:REG_A_END], t1_fb,
                state_q[REG_A_END-2:0], t3_fb};
    state_d  = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = step_val;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/trivium_decrypt.sv
// Trivium stream decryptor: warms up the cipher, buffers one W-bit keystream word and XORs it onto ciphertext.
// Latency: first ct_ready WARMUP+W edges after start; plaintext registered one cycle after each ct handshake.
// Backpressure: keystream generation stalls in FULL until a ct word is accepted; ct_ready follows pt_ready when pt is occupied.
import trivium_pkg::*;

module trivium_decrypt #(
  parameter int W      = 8,
  parameter int WARMUP = WARMUP_ROUNDS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [IV_W-1:0]  iv,
  input  logic [W-1:0]     ct_data,
  input  logic             ct_valid,
  output logic             ct_ready,
  output logic [W-1:0]     pt_data,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic             busy
);

  localparam int BIT_CNT_W = $clog2(W + 1);

  dec_state_e             state_q;
  logic [10:0]            warm_cnt_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [W-1:0]           ks_buf_q;
  logic [W-1:0]           pt_data_q;
  logic                   pt_valid_q;
  logic                   busy_q;

  logic                   core_step;
  logic                   ks_bit;
  logic                   ct_hs;
  logic [STATE_W-1:0]     core_state_unused;

  trivium_core u_core (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .key   (key),
    .iv    (iv),
    .step  (core_step),
    .z     (ks_bit),
    .state (core_state_unused)
  );

  // The cipher only advances while warming up or filling the buffer, so stalls in FULL never lose keystream
  always_comb begin
    core_step = !start && ((state_q == WARM) || (state_q == FILL));
    ct_ready  = !start && (state_q == FULL) && (!pt_valid_q || pt_ready);
    ct_hs     = ct_ready && ct_valid;
  end

  // Session FSM, keystream buffer and plaintext output register; start overrides everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      ks_buf_q   <= '0;
      pt_data_q  <= '0;
      pt_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (start) begin
      state_q    <= WARM;
      warm_cnt_q <= '0;
      bit_cnt_q  <= '0;
      ks_buf_q   <= '0;
      pt_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      if (ct_hs) begin
        pt_data_q  <= ct_data ^ ks_buf_q;
        pt_valid_q <= 1'b1;
      end else if (pt_ready) begin
        pt_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
        end
        WARM: begin
          if (warm_cnt_q == 11'(WARMUP - 1)) begin
            state_q   <= FILL;
            busy_q    <= 1'b0;
            bit_cnt_q <= '0;
          end else begin
            warm_cnt_q <= warm_cnt_q + 11'd1;
          end
        end
        FILL: begin
          // First keystream bit of a word lands in the LSB
          for (int i = 0; i < W; i++) begin
            if (bit_cnt_q == BIT_CNT_W'(i)) begin
              ks_buf_q[i] <= ks_bit;
            end
          end
          if (bit_cnt_q == BIT_CNT_W'(W - 1)) begin
            state_q <= FULL;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        FULL: begin
          if (ct_hs) begin
            state_q   <= FILL;
            bit_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pt_data  = pt_data_q;
  assign pt_valid = pt_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_trivium_decrypt.sv
// Directed bench for trivium_decrypt with an independent bit-level Trivium reference.
// Latency: n/a (testbench).
// Backpressure: random ct gaps and 30% pt_ready duty in the stall scenario.
module tb_trivium_decrypt;

  localparam int W      = 8;
  localparam int WARMUP = 1152;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [79:0]   key;
  logic [79:0]   iv;
  logic [W-1:0]  ct_data;
  logic          ct_valid;
  logic          ct_ready;
  logic [W-1:0]  pt_data;
  logic          pt_valid;
  logic          pt_ready;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [287:0]  ms;
  logic [W-1:0]  ct_q[$];
  logic [W-1:0]  ks_q[$];
  logic [W-1:0]  got_q[$];
  logic [W-1:0]  nostall_q[$];
  int            drop_viol;

  localparam logic [79:0] K_RT  = 80'h0123456789ABCDEF0123;
  localparam logic [79:0] IV_RT = 80'hFEDCBA98765432100000;

  trivium_decrypt #(.W(W), .WARMUP(WARMUP)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .iv       (iv),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference Trivium, addressed 1-based as s(i) = ms[i-1]
  function automatic logic sb(input int i);
    return ms[i-1];
  endfunction

  task automatic model_load(input logic [79:0] k, input logic [79:0] v);
    ms = '0;
    for (int i = 1; i <= 80; i++) ms[i-1] = k[i-1];
    for (int i = 1; i <= 80; i++) ms[i+93-1] = v[i-1];
    ms[285] = 1'b1;
    ms[286] = 1'b1;
    ms[287] = 1'b1;
  endtask

  task automatic model_step(output logic zo);
    logic a1, a2, a3, f1, f2, f3;
    a1 = sb(66) ^ sb(93);
    a2 = sb(162) ^ sb(177);
    a3 = sb(243) ^ sb(288);
    zo = a1 ^ a2 ^ a3;
    f1 = a1 ^ (sb(91) & sb(92)) ^ sb(171);
    f2 = a2 ^ (sb(175) & sb(176)) ^ sb(264);
    f3 = a3 ^ (sb(286) & sb(287)) ^ sb(69);
    for (int i = 288; i >= 2; i--) begin
      if (i != 94 && i != 178) ms[i-1] = ms[i-2];
    end
    ms[0]   = f3;
    ms[93]  = f1;
    ms[177] = f2;
  endtask

  task automatic model_keystream(input logic [79:0] k, input logic [79:0] v, input int n);
    logic zb;
    logic [W-1:0] wd;
    model_load(k, v);
    for (int i = 0; i < WARMUP; i++) model_step(zb);
    ks_q.delete();
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < W; b++) begin
        model_step(zb);
        wd[b] = zb;
      end
      ks_q.push_back(wd);
    end
  endtask

  // Streams ct_q through the DUT, collecting accepted plaintext into got_q; starts and ends on a negedge
  task automatic run_stream(input logic [79:0] k, input logic [79:0] v, input bit do_start, input bit stall);
    int idx;
    int cyc;
    int limit;
    bit prev_v;
    bit prev_hs;
    got_q.delete();
    drop_viol = 0;
    if (do_start) begin
      @(negedge clk);
      key = k; iv = v; start = 1'b1; ct_valid = 1'b0; pt_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    idx = 0; cyc = 0; prev_v = 1'b0; prev_hs = 1'b0;
    limit = WARMUP + ct_q.size() * W * 20 + 400;
    while (got_q.size() < ct_q.size() && cyc < limit) begin
      if (prev_v && !prev_hs && !pt_valid) drop_viol++;
      ct_valid = (idx < ct_q.size()) && (!stall || ($urandom_range(0, 99) >= 40));
      ct_data  = (idx < ct_q.size()) ? ct_q[idx] : '0;
      pt_ready = !stall || ($urandom_range(0, 99) < 30);
      #1;
      prev_v  = pt_valid;
      prev_hs = pt_valid && pt_ready;
      if (pt_valid && pt_ready) got_q.push_back(pt_data);
      if (ct_valid && ct_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    ct_valid = 1'b0;
    pt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; key = '0; iv = '0;
    ct_data = '0; ct_valid = 1'b0; pt_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (pt_valid !== 1'b0) $display("FAIL reset_pt_valid got=%b exp=0", pt_valid); else n_pass++;
    n_checks++; if (pt_data !== 8'h00) $display("FAIL reset_pt_data got=%h exp=00", pt_data); else n_pass++;
    n_checks++; if (ct_ready !== 1'b0) $display("FAIL reset_ct_ready got=%b exp=0", ct_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_startup();
    int busy_fall;
    int rdy_rise;
    model_keystream(80'h0, 80'h0, 1);
    @(negedge clk);
    key = '0; iv = '0; ct_data = '0; ct_valid = 1'b1; pt_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL startup_busy_rise got=%b exp=1", busy); else n_pass++;
    busy_fall = -1; rdy_rise = -1;
    for (int n = 0; n < 1400 && (busy_fall < 0 || rdy_rise < 0); n++) begin
      if (busy_fall < 0 && !busy) busy_fall = n;
      if (rdy_rise < 0 && ct_ready) rdy_rise = n;
      @(posedge clk);
      #1;
    end
    n_checks++; if (busy_fall !== 1152) $display("FAIL startup_busy_len got=%0d exp=1152", busy_fall); else n_pass++;
    n_checks++; if (rdy_rise !== 1160) $display("FAIL startup_ct_ready got=%0d exp=1160", rdy_rise); else n_pass++;
    n_checks++; if (pt_valid !== 1'b1 || pt_data !== ks_q[0])
      $display("FAIL startup_first_word got=%b/%h exp=1/%h", pt_valid, pt_data, ks_q[0]); else n_pass++;
  endtask

  task automatic test_keystream();
    ct_q.delete();
    for (int i = 0; i < 16; i++) ct_q.push_back(8'h00);
    model_keystream(80'h80000000000000000000, 80'h0, 16);
    run_stream(80'h80000000000000000000, 80'h0, 1'b1, 1'b0);
    n_checks++; if (got_q.size() != 16) $display("FAIL keystream_count got=%0d exp=16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== ks_q[i]) $display("FAIL keystream_word%0d got=%h exp=%h", i, got_q[i], ks_q[i]); else n_pass++;
    end
    nostall_q = got_q;
  endtask

  task automatic test_round_trip();
    logic [W-1:0] payload[$];
    model_keystream(K_RT, IV_RT, 64);
    ct_q.delete();
    for (int i = 0; i < 64; i++) begin
      payload.push_back(W'($urandom_range(0, 255)));
      ct_q.push_back(payload[i] ^ ks_q[i]);
    end
    run_stream(K_RT, IV_RT, 1'b1, 1'b0);
    n_checks++; if (got_q.size() != 64) $display("FAIL roundtrip_count got=%0d exp=64", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== payload[i]) $display("FAIL roundtrip_byte%0d got=%h exp=%h", i, got_q[i], payload[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    ct_q.delete();
    for (int i = 0; i < 16; i++) ct_q.push_back(8'h00);
    run_stream(80'h80000000000000000000, 80'h0, 1'b1, 1'b1);
    n_checks++; if (got_q.size() != 16) $display("FAIL backpressure_count got=%0d exp=16", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < nostall_q.size(); i++) begin
      n_checks++; if (got_q[i] !== nostall_q[i]) $display("FAIL backpressure_word%0d got=%h exp=%h", i, got_q[i], nostall_q[i]); else n_pass++;
    end
    n_checks++; if (drop_viol != 0) $display("FAIL backpressure_valid_drop got=%0d exp=0", drop_viol); else n_pass++;
  endtask

  task automatic test_abort();
    logic [79:0] iv_a;
    logic [79:0] iv_b;
    logic [W-1:0] exp6;
    bit ok;
    iv_a = 80'h00000000000000000001;
    iv_b = 80'h0000000000000000BEEF;
    model_keystream(K_RT, iv_a, 6);
    exp6 = 8'hA5 ^ ks_q[5];
    ct_q.delete();
    for (int i = 0; i < 5; i++) ct_q.push_back(8'h00);
    run_stream(K_RT, iv_a, 1'b1, 1'b0);
    n_checks++; if (got_q.size() != 5) $display("FAIL abort_first_count got=%0d exp=5", got_q.size()); else n_pass++;
    // Park a sixth word in the output register
    ct_valid = 1'b1; ct_data = 8'hA5; pt_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      ok = ct_ready;
      @(negedge clk);
    end
    ct_valid = 1'b0;
    n_checks++; if (pt_valid !== 1'b1 || pt_data !== exp6)
      $display("FAIL abort_pending got=%b/%h exp=1/%h", pt_valid, pt_data, exp6); else n_pass++;
    iv = iv_b; start = 1'b1; ct_valid = 1'b1; ct_data = 8'h3C;
    #1;
    n_checks++; if (ct_ready !== 1'b0) $display("FAIL abort_ct_ready_on_start got=%b exp=0", ct_ready); else n_pass++;
    @(negedge clk);
    start = 1'b0; ct_valid = 1'b0;
    n_checks++; if (pt_valid !== 1'b0) $display("FAIL abort_pt_valid got=%b exp=0", pt_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL abort_busy got=%b exp=1", busy); else n_pass++;
    model_keystream(K_RT, iv_b, 8);
    ct_q.delete();
    for (int i = 0; i < 8; i++) ct_q.push_back(8'h00);
    run_stream(K_RT, iv_b, 1'b0, 1'b0);
    n_checks++; if (got_q.size() != 8) $display("FAIL abort_new_count got=%0d exp=8", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== ks_q[i]) $display("FAIL abort_new_word%0d got=%h exp=%h", i, got_q[i], ks_q[i]); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int idle_bad;
    ct_q.delete();
    for (int i = 0; i < 2; i++) ct_q.push_back(8'h00);
    run_stream(K_RT, IV_RT, 1'b1, 1'b0);
    // Accept one more word so the block sits in FILL with pt_valid high
    ct_valid = 1'b1; ct_data = 8'h00; pt_ready = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      ok = ct_ready;
      @(negedge clk);
    end
    ct_valid = 1'b0;
    n_checks++; if (pt_valid !== 1'b1) $display("FAIL areset_pre_pt_valid got=%b exp=1", pt_valid); else n_pass++;
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (pt_valid !== 1'b0) $display("FAIL areset_pt_valid got=%b exp=0", pt_valid); else n_pass++;
    n_checks++; if (ct_ready !== 1'b0) $display("FAIL areset_ct_ready got=%b exp=0", ct_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (pt_data !== 8'h00) $display("FAIL areset_pt_data got=%h exp=00", pt_data); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    ct_valid = 1'b1; pt_ready = 1'b1;
    idle_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (ct_ready || busy || pt_valid) idle_bad++;
    end
    ct_valid = 1'b0; pt_ready = 1'b0;
    n_checks++; if (idle_bad != 0) $display("FAIL areset_stays_idle got=%0d exp=0", idle_bad); else n_pass++;
    model_keystream(K_RT, 80'h0, 2);
    run_stream(K_RT, 80'h0, 1'b1, 1'b0);
    n_checks++; if (got_q.size() != 2) $display("FAIL areset_restart_count got=%0d exp=2", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== ks_q[i]) $display("FAIL areset_restart_word%0d got=%h exp=%h", i, got_q[i], ks_q[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_keystream();
    test_round_trip();
    test_backpressure();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trivium_decrypt.md
Name: trivium_decrypt

Overview:
- Receive-side counterpart of the team's Trivium keystream encryptor. Regenerates the same keystream from KEY/IV and XORs it onto incoming ciphertext words to recover plaintext.
- Streaming block: ciphertext arrives on a valid/ready input and plaintext leaves on a valid/ready output.
- Sits between the link receiver and the payload consumer. One instance serves one session, with a start pulse per session.

Parameters:
- W, 8, data word width in bits (1..64); one keystream bit is generated per clock, so peak throughput is one word per W clocks.
- WARMUP, 1152, number of blank initialisation rounds (4*288).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; samples key/iv and begins a new session.
- key  in  80  key; key[i] loads state bit s(i+1).
- iv  in  80  IV; iv[i] loads state bit s(i+94).
- ct_data  in  W  ciphertext word.
- ct_valid  in  1  ciphertext word present.
- ct_ready  out  1  block accepts ct_data this cycle.
- pt_data  out  W  plaintext word (registered).
- pt_valid  out  1  pt_data valid.
- pt_ready  in  1  consumer accepts pt_data.
- busy  out  1  high from the start edge until warm-up completes.

Behaviour:
- Reset (async, active-high) values: state=IDLE, pt_valid=0, pt_data=0, ct_ready=0, busy=0. The 288-bit state, counters and keystream buffer are all cleared to 0.
- Trivium state is s1..s288. Load on the start edge sets:
  - s1..s80=key, s81..s93=0;
  - s94..s173=iv, s174..s177=0;
  - s178..s285=0, s286..s288=1.
- Step equations (one step per clock, for both warm-up and generation):
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1'=t1^(s91&s92)^s171; t2'=t2^(s175&s176)^s264; t3'=t3^(s286&s287)^s69.
  - (s1..s93)<=(t3',s1..s92); (s94..s177)<=(t1',s94..s176); (s178..s288)<=(t2',s178..s287).
  - z is discarded during warm-up.
- FSM states:
  - IDLE: no stepping. start -> WARM (load performed on the same edge, counter=0).
  - WARM: step every clock. After WARMUP steps -> FILL, busy drops.
  - FILL: step every clock and write z into ks_buf[bitcnt], so the first keystream bit goes to the LSB of the word. After W steps -> FULL.
  - FULL: no stepping (keystream generation stalls). ct_ready = ct_valid-independent (!pt_valid | pt_ready).
  - On a ct handshake: pt_data <= ct_data ^ ks_buf, pt_valid <= 1, state -> FILL, bitcnt=0.
- Output register: pt_valid clears on pt_ready when no new word is loaded the same cycle. A simultaneous pt handshake and ct handshake reloads pt_data with no bubble.
- Latency: counting the start edge as edge 0, ct_ready first rises after edge WARMUP+W (1160 for W=8). For a given word, the plaintext appears on pt_data the cycle after the ct handshake.
- ct_ready is 0 in IDLE, WARM and FILL, and whenever start=1.
- start in any non-IDLE state aborts the session:
  - key/iv are reloaded, the counters restart and ks_buf is cleared;
  - pt_valid is forced to 0 and any pending plaintext is dropped;
  - the FSM returns to WARM.
- start has priority over any handshake in the same cycle.
- Keystream continuity: successive words consume consecutive keystream bits with no gaps; stalls on ct_valid or pt_ready never advance the state.
- Counter widths: warm-up counter is 11 bits; bit counter is clog2(W+1) bits. Neither counter wraps; each is reset on its state entry.

Decomposition:
- Package trivium_pkg holds: STATE_W=288, KEY_W=80, IV_W=80, WARMUP_ROUNDS=1152, the tap-position constants, and the FSM state enum (IDLE, WARM, FILL, FULL).
- Sub-module trivium_core:
  - inputs: load, key, iv, step;
  - outputs: z and the 288-bit state;
  - contains the load mux and the one-step update only.
- trivium_decrypt wraps trivium_core with the FSM, the keystream buffer and the handshake logic. The encryptor should later reuse trivium_core.

Test Plan:
- Startup timing: reset, key=0, iv=0, start; hold ct_valid=1, pt_ready=1 -> busy high for 1152 cycles; ct_ready first high exactly 1160 cycles after the start edge (W=8).
- Keystream check: key=0x80000000000000000000 (bit79 set), iv=0, ciphertext stream of 16 x 0x00 -> pt words equal the golden software Trivium keystream, LSB-first packing, bit-exact.
- Round trip: encrypt a 64-byte random payload with the golden model under key=0x0123456789ABCDEF0123, iv=0xFEDCBA98765432100000 and feed it in -> recovered bytes equal the payload.
- Backpressure: pt_ready toggled at random with 30% duty and ct_valid gapped at random -> output identical to the no-stall run; no pt_valid drop without a handshake; state never advances in FULL.
- Abort: issue start mid-stream after word 5, with a different iv -> pt_valid=0 on the next cycle, busy re-asserts, and the following words match the new session's keystream from bit 1.
- Async reset: assert reset during FILL, asynchronously to clk -> pt_valid, ct_ready and busy go to 0 immediately; the block stays in IDLE until the next start.
